throttle_conditioner: RTL

Conditions the raw 12-bit hand-throttle ADC sample and produces a clean 10-bit motor demand. The input comes from the throttle channel of the ADC controller, channel 1. The output goes to the motor control block, in the same 10-bit width as the PWM demand. Processing is: fixed-rate sampling, moving average, deadband and scaling, upward slew limiting, brake override, and open/short-wire fault detection.

---
 rtl/throttle_conditioner.sv | 280 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/throttle_conditioner.sv
// Throttle conditioner: 12-bit ADC throttle code -> 10-bit motor demand with averaging,
// deadband/scaling, upward slew limit, brake override and open/short wire fault detection.
// Define THROTTLE_STATS_EN to add the avg_raw and fault_events observation ports.
module throttle_conditioner #(
    parameter int CLK_HZ      = 50000000,
    parameter int SAMPLE_HZ   = 1000,
    parameter int AVG_LOG2    = 3,
    parameter int DEADBAND    = 200,
    parameter int FULL_SCALE  = 3800,
    parameter int SLEW_STEP   = 4,
    parameter int FAULT_LOW   = 40,
    parameter int FAULT_HIGH  = 4050,
    parameter int FAULT_TICKS = 16
) (
    input  logic        c50m,
    input  logic        reset,
    input  logic [11:0] adc_sample,
    input  logic        brakes,
    output logic [9:0]  throttle_out,
    output logic        throttle_valid,
    output logic        throttle_fault
`ifdef THROTTLE_STATS_EN
    ,
    output logic [11:0] avg_raw,
    output logic [7:0]  fault_events
`endif
);
    localparam int DIV        = CLK_HZ / SAMPLE_HZ;
    localparam int CW         = $clog2(DIV);
    localparam int DEPTH      = 1 << AVG_LOG2;
    localparam int SW         = 12 + AVG_LOG2;
    localparam int FW         = AVG_LOG2 + 1;
    localparam int BW         = $clog2(FAULT_TICKS + 1);
    localparam int GAIN       = (1023 * 4096) / (FULL_SCALE - DEADBAND);
    localparam int EXIT_TICKS = 8;

    localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
    localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);
    localparam logic [BW-1:0] BAD_LIMIT = BW'(FAULT_TICKS);
    localparam logic [11:0]   DB_C      = 12'(DEADBAND);
    localparam logic [11:0]   FS_C      = 12'(FULL_SCALE);
    localparam logic [11:0]   FL_C      = 12'(FAULT_LOW);
    localparam logic [11:0]   FH_C      = 12'(FAULT_HIGH);
    localparam logic [9:0]    STEP_C    = 10'(SLEW_STEP);
    localparam logic [3:0]    EXIT_C    = 4'(EXIT_TICKS);

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_RUN   = 2'd1,
        ST_BRAKE = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    logic [CW-1:0]       cnt_q, cnt_d;
    logic                tick_s;
    logic                brk_meta_q, brk_s_q;
    logic [11:0]         ring_q [DEPTH];
    logic [SW-1:0]       sum_q, sum_d;
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [FW-1:0]       fill_q, fill_d;
    logic                s1v_q;
    logic [11:0]         avg_s;
    logic [31:0]         scaled_s;
    logic [9:0]          target_s;
    logic                oor_s;
    logic [BW-1:0]       bad_q, bad_d;
    logic                fault_hit_s;
    state_t              state_q, state_d;
    logic [9:0]          out_q, out_d;
    logic                valid_q;
    logic                fault_q;
    logic [3:0]          ok_q, ok_d;

    // Sample-rate divider: tick marks the last cycle of each sample period
    always_comb begin
        tick_s = (cnt_q == CNT_LAST);
        if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Two-flop synchronizer for the asynchronous brake lever
    always_ff @(posedge c50m or posedge reset) begin
        if (reset) begin
            brk_meta_q <= 1'b0;
            brk_s_q    <= 1'b0;
        end else begin
            brk_meta_q <= brakes;
            brk_s_q    <= brk_meta_q;
        end
    end

    // Stage 1 next state: running sum stays exact by subtracting the evicted slot
    always_comb begin
        sum_d    = sum_q;
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        if (tick_s) begin
            sum_d    = sum_q + SW'(adc_sample) - SW'(ring_q[wr_ptr_q]);
            wr_ptr_d = wr_ptr_q + AVG_LOG2'(1);
            if (fill_q != FILL_FULL) begin
                fill_d = fill_q + FW'(1);
            end else begin
                fill_d = fill_q;
            end
        end else begin
            sum_d    = sum_q;
            wr_ptr_d = wr_ptr_q;
            fill_d   = fill_q;
        end
    end

    // Stage 1 registers: divider, ring buffer, sum, pointer and fill count
    always_ff @(posedge c50m or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            sum_q    <= '0;
            wr_ptr_q <= '0;
            fill_q   <= '0;
            s1v_q    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                ring_q[i] <= 12'd0;
            end
        end else begin
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
            s1v_q    <= tick_s;
            if (tick_s) begin
                ring_q[wr_ptr_q] <= adc_sample;
            end
        end
    end

    // Stage 2: average, deadband/scale to target, and out-of-range run length
    always_comb begin
        avg_s    = sum_q[SW-1:AVG_LOG2];
        scaled_s = ((32'(avg_s) - 32'(DB_C)) * 32'(GAIN)) >> 12;
        if (avg_s <= DB_C) begin
            target_s = 10'd0;
        end else if (avg_s >= FS_C) begin
            target_s = 10'd1023;
        end else if (scaled_s > 32'd1023) begin
            target_s = 10'd1023;
        end else begin
            target_s = scaled_s[9:0];
        end
        oor_s = (avg_s < FL_C) || (avg_s > FH_C);
        if (!s1v_q) begin
            bad_d = bad_q;
        end else if (!oor_s) begin
            bad_d = '0;
        end else if (bad_q == BAD_LIMIT) begin
            bad_d = bad_q;
        end else begin
            bad_d = bad_q + BW'(1);
        end
        fault_hit_s = s1v_q && (bad_d == BAD_LIMIT);
    end

    // Stage 3 state machine; fault outranks brake, brake outranks slew
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        ok_d    = ok_q;
        case (state_q)
            ST_FILL: begin
                out_d = 10'd0;
                if (brk_s_q) begin
                    state_d = ST_BRAKE;
                end else if (s1v_q && (fill_q == FILL_FULL)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_RUN, ST_BRAKE: begin
                if (fault_hit_s) begin
                    state_d = ST_FAULT;
                    out_d   = 10'd0;
                    ok_d    = 4'd0;
                end else if (brk_s_q) begin
                    state_d = ST_BRAKE;
                    out_d   = 10'd0;
                end else if (state_q == ST_BRAKE) begin
                    state_d = ST_RUN;
                    out_d   = 10'd0;
                end else if (s1v_q) begin
                    state_d = ST_RUN;
                    if ((target_s > out_q) && ((target_s - out_q) > STEP_C)) begin
                        out_d = out_q + STEP_C;
                    end else begin
                        out_d = target_s;
                    end
                end else begin
                    state_d = ST_RUN;
                    out_d   = out_q;
                end
            end
            ST_FAULT: begin
                out_d = 10'd0;
                if (!s1v_q) begin
                    ok_d = ok_q;
                end else if (oor_s || (target_s != 10'd0)) begin
                    ok_d = 4'd0;
                end else if ((ok_q + 4'd1) == EXIT_C) begin
                    ok_d    = 4'd0;
                    state_d = ST_RUN;
                end else begin
                    ok_d = ok_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_FILL;
                out_d   = 10'd0;
                ok_d    = 4'd0;
            end
        endcase
    end

    // Stage 2/3 registers and registered outputs
    always_ff @(posedge c50m or posedge reset) begin
        if (reset) begin
            state_q <= ST_FILL;
            out_q   <= 10'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            ok_q    <= 4'd0;
            bad_q   <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            valid_q <= s1v_q;
            fault_q <= (state_d == ST_FAULT);
            ok_q    <= ok_d;
            bad_q   <= bad_d;
        end
    end

    assign throttle_out   = out_q;
    assign throttle_valid = valid_q;
    assign throttle_fault = fault_q;

`ifdef THROTTLE_STATS_EN
    logic [11:0] avg_raw_q, avg_raw_d;
    logic [7:0]  fev_q, fev_d;

    // Observation counters: last stage-2 average and saturating fault-entry count
    always_comb begin
        if (s1v_q) begin
            avg_raw_d = avg_s;
        end else begin
            avg_raw_d = avg_raw_q;
        end
        if ((state_d == ST_FAULT) && (state_q != ST_FAULT) && (fev_q != 8'd255)) begin
            fev_d = fev_q + 8'd1;
        end else begin
            fev_d = fev_q;
        end
    end

    // Observation registers
    always_ff @(posedge c50m or posedge reset) begin
        if (reset) begin
            avg_raw_q <= 12'd0;
            fev_q     <= 8'd0;
        end else begin
            avg_raw_q <= avg_raw_d;
            fev_q     <= fev_d;
        end
    end

    assign avg_raw      = avg_raw_q;
    assign fault_events = fev_q;
`endif

endmodule
